// File: rtl/prog_counter_fetch_pkg.sv
// fetch_pkg: shared fetch-stage state encoding and default widths used by ROM, decode and fetch.
package fetch_pkg;
    localparam int DEF_A    = 10;
    localparam int DEF_OFFW = 6;
    localparam int DEF_L    = 4;
    localparam int DEF_CW   = 16;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
endpackage

// File: rtl/prog_counter_fetch_if.sv
// prog_counter_fetch_if: control inputs from decode and the PC/status outputs of the fetch stage.
interface prog_counter_fetch_if #(
    parameter int A    = 10,
    parameter int OFFW = 6,
    parameter int L    = 4,
    parameter int CW   = 16
);
    logic            Start;
    logic [A-1:0]    StartAddr;
    logic            Stall;
    logic            HaltReq;
    logic            BranchEn;
    logic            BranchRel;
    logic [OFFW-1:0] BranchOffset;
    logic [L-1:0]    LutIndex;
    logic [A-1:0]    InstAddress;
    logic            Fetching;
    logic            Done;
    logic [CW-1:0]   CycleCount;
    logic [CW-1:0]   InstCount;

    modport master (
        output Start, StartAddr, Stall, HaltReq, BranchEn, BranchRel, BranchOffset, LutIndex,
        input  InstAddress, Fetching, Done, CycleCount, InstCount
    );
    modport slave (
        input  Start, StartAddr, Stall, HaltReq, BranchEn, BranchRel, BranchOffset, LutIndex,
        output InstAddress, Fetching, Done, CycleCount, InstCount
    );
endinterface

// File: rtl/prog_counter_fetch_branch_lut.sv
// branch_lut: combinational table of absolute branch targets; contents come from the INIT parameter.
module branch_lut #(
    parameter int A = 10,
    parameter int L = 4,
    parameter logic [(2**L)*A-1:0] INIT = '0
) (
    input  logic [L-1:0] idx,
    output logic [A-1:0] target
);
    assign target = INIT[idx*A +: A];
endmodule

// File: rtl/prog_counter_fetch.sv
// prog_counter_fetch: fetch-stage PC sequencer (start, increment, stall, branches, halt)
// with saturating cycle and retired-instruction counters.
module prog_counter_fetch
    import fetch_pkg::*;
#(
    parameter int A    = DEF_A,
    parameter int OFFW = DEF_OFFW,
    parameter int L    = DEF_L,
    parameter int CW   = DEF_CW,
    parameter logic [(2**L)*A-1:0] LUT_INIT = '0
) (
    input logic Clk,
    input logic Reset,
    prog_counter_fetch_if.slave bus
);
    state_t        state, state_nx;
    logic [A-1:0]  pc, pc_nx, lut_target;
    logic [CW-1:0] cyc, cyc_nx, inst, inst_nx;

    branch_lut #(.A(A), .L(L), .INIT(LUT_INIT)) u_lut (
        .idx   (bus.LutIndex),
        .target(lut_target)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            pc    <= '0;
            cyc   <= '0;
            inst  <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            cyc   <= cyc_nx;
            inst  <= inst_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cyc_nx   = cyc;
        inst_nx  = inst;
        case (state)
            RUN: begin
                cyc_nx = (cyc == '1) ? cyc : cyc + 1'b1;
                // a stalled edge retires nothing; decode re-presents halt/branch next cycle
                if (!bus.Stall) begin
                    inst_nx  = (inst == '1) ? inst : inst + 1'b1;
                    state_nx = bus.HaltReq ? HALTED : RUN;
                    pc_nx    = bus.HaltReq   ? pc :
                               !bus.BranchEn ? pc + 1'b1 :
                               bus.BranchRel ? pc + A'($signed(bus.BranchOffset)) : lut_target;
                end
            end
            default: begin
                if (bus.Start) begin
                    state_nx = RUN;
                    pc_nx    = bus.StartAddr;
                    cyc_nx   = '0;
                    inst_nx  = '0;
                end
            end
        endcase
    end

    assign bus.InstAddress = pc;
    assign bus.Fetching    = (state == RUN);
    assign bus.Done        = (state == HALTED);
    assign bus.CycleCount  = cyc;
    assign bus.InstCount   = inst;
endmodule

// File: tb/tb_prog_counter_fetch.sv
// tb_prog_counter_fetch: directed plus randomized checks of prog_counter_fetch against a behavioural model.
module tb_prog_counter_fetch;
    localparam int A    = 10;
    localparam int OFFW = 6;
    localparam int L    = 4;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    function automatic logic [(2**L)*A-1:0] make_lut();
        logic [(2**L)*A-1:0] v;
        v = '0;
        for (int i = 0; i < 2**L; i++)
            v[i*A +: A] = (i == 5) ? A'(10'h100) : A'((i * 37 + 3) % 1024);
        return v;
    endfunction

    localparam logic [(2**L)*A-1:0] LUT = make_lut();

    logic Clk = 0;
    logic Reset = 0;
    int   checks = 0;
    int   errors = 0;

    int m_state, m_pc, m_cyc, m_inst;

    prog_counter_fetch_if #(.A(A), .OFFW(OFFW), .L(L), .CW(CW)) bus ();

    prog_counter_fetch #(.A(A), .OFFW(OFFW), .L(L), .CW(CW), .LUT_INIT(LUT)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},   int'(bus.InstAddress), m_pc);
        check({tag, ".fetch"}, int'(bus.Fetching), int'(m_state == 1));
        check({tag, ".done"}, int'(bus.Done), int'(m_state == 2));
        check({tag, ".cyc"},  int'(bus.CycleCount), m_cyc);
        check({tag, ".inst"}, int'(bus.InstCount), m_inst);
    endtask

    task automatic clear_in();
        bus.Start = 0; bus.StartAddr = 0; bus.Stall = 0; bus.HaltReq = 0;
        bus.BranchEn = 0; bus.BranchRel = 0; bus.BranchOffset = 0; bus.LutIndex = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_cyc = 0; m_inst = 0;
    endtask

    // One rising edge: advance the model from the presented inputs, then compare.
    task automatic tick(input string tag);
        int off;
        @(posedge Clk);
        if (Reset) begin
            if (m_state != 1) begin
                if (bus.Start) begin
                    m_state = 1; m_pc = int'(bus.StartAddr); m_cyc = 0; m_inst = 0;
                end
            end else begin
                m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
                if (!bus.Stall) begin
                    m_inst = (m_inst < CMAX) ? m_inst + 1 : CMAX;
                    off = int'(bus.BranchOffset);
                    if (off >= 32) off -= 64;
                    if (bus.HaltReq) m_state = 2;
                    else if (bus.BranchEn && bus.BranchRel) m_pc = (m_pc + off + 1024) % 1024;
                    else if (bus.BranchEn) m_pc = int'(LUT[int'(bus.LutIndex)*A +: A]);
                    else m_pc = (m_pc + 1) % 1024;
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic restart(input int addr);
        clear_in(); bus.HaltReq = 1; tick("halt");
        clear_in(); bus.Start = 1; bus.StartAddr = A'(addr); tick("start");
        clear_in();
    endtask

    initial begin
        clear_in();
        model_reset();
        #1;
        check_all("reset");
        #12 Reset = 1;

        clear_in(); bus.Start = 1; bus.StartAddr = 10'h020; tick("first_start");
        clear_in();
        repeat (5) tick("seq_to_025");
        check("pc_025", int'(bus.InstAddress), 'h025);
        Reset = 0;
        model_reset();
        #1;
        check_all("async_reset");
        Reset = 1;
        bus.Start = 1; bus.StartAddr = 10'h010; tick("start_010");
        check("pc_010", int'(bus.InstAddress), 'h010);

        restart('h3FD);
        repeat (4) tick("wrap_seq");
        check("wrap_pc", int'(bus.InstAddress), 'h001);
        check("wrap_inst", int'(bus.InstCount), 4);

        restart('h020);
        bus.BranchEn = 1; bus.BranchRel = 1; bus.BranchOffset = 6'b111101; tick("rel_m3");
        check("rel_m3_pc", int'(bus.InstAddress), 'h01D);
        restart('h001);
        bus.BranchEn = 1; bus.BranchRel = 1; bus.BranchOffset = 6'b111100; tick("rel_wrap");
        check("rel_wrap_pc", int'(bus.InstAddress), 'h3FD);

        bus.BranchEn = 1; bus.BranchRel = 0; bus.LutIndex = 5; bus.Stall = 1; tick("abs_stall");
        check("abs_stall_pc", int'(bus.InstAddress), 'h3FD);
        bus.Stall = 0; tick("abs");
        check("abs_pc", int'(bus.InstAddress), 'h100);

        restart('h038);
        repeat (10) tick("pre_halt");
        bus.HaltReq = 1; tick("halt_042");
        check("halt_inst", int'(bus.InstCount), 11);
        check("halt_done", int'(bus.Done), 1);
        clear_in(); repeat (2) tick("halted_hold");
        bus.Start = 1; bus.StartAddr = 0; tick("restart_0");
        clear_in();

        bus.Start = 1; bus.StartAddr = 10'h200;
        repeat (CMAX + 4) tick("saturate");
        check("sat_inst", int'(bus.InstCount), CMAX);

        for (int i = 0; i < 3000; i++) begin
            bus.Start        = ($urandom_range(0, 7) == 0);
            bus.StartAddr    = A'($urandom);
            bus.Stall        = ($urandom_range(0, 3) == 0);
            bus.HaltReq      = ($urandom_range(0, 31) == 0);
            bus.BranchEn     = ($urandom_range(0, 2) == 0);
            bus.BranchRel    = 1'($urandom);
            bus.BranchOffset = OFFW'($urandom);
            bus.LutIndex     = L'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                Reset = 0;
                model_reset();
                #1;
                check_all("rand_reset");
                Reset = 1;
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
